// File: rtl/spi_sdcmd_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// spi_sdcmd_engine
//   SPI-mode SD card command engine. Issues the card power-up clock train,
//   shifts out one command frame, waits for the card's response start bit and
//   captures a response of a programmable byte length.
//
// Ports
//   spi_clk_i       sole clock (rising edge)
//   spi_rst_i       synchronous active-high reset
//   spi_init_i      request the power-up clock sequence (SS high, MOSI high)
//   spi_start_i     command-start strobe, honoured in IDLE after init
//   spi_cs_sel_i    target slave index (out-of-range index selects nobody)
//   spi_cmd_i       command frame, sent MSB first
//   spi_rsplen_i    response length in bytes (0 -> 1, clamped to RSP_W/8)
//   spi_div_i       SCK half-period minus one, in spi_clk_i cycles
//   MISO            serial data from card
//   spi_data_o      last completed response, right-aligned, upper bits zero
//   spi_flagreg_o   {timeout, done, busy}
//   MOSI/SCK_SPI/SS SPI mode 0 bus, SS active low
//   spi_initdone_o  set once the power-up sequence has completed
// ---------------------------------------------------------------------------
module spi_sdcmd_engine #(
    parameter int unsigned CMD_W     = 48,
    parameter int unsigned RSP_W     = 40,
    parameter int unsigned NUM_CS    = 2,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned INIT_CLKS = 80,
    parameter int unsigned NCR_MAX   = 8,
    localparam int unsigned CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              spi_clk_i,
    input  logic              spi_rst_i,
    input  logic              spi_init_i,
    input  logic              spi_start_i,
    input  logic [CS_W-1:0]   spi_cs_sel_i,
    input  logic [CMD_W-1:0]  spi_cmd_i,
    input  logic [3:0]        spi_rsplen_i,
    input  logic [DIV_W-1:0]  spi_div_i,
    input  logic              MISO,
    output logic [RSP_W-1:0]  spi_data_o,
    output logic [2:0]        spi_flagreg_o,
    output logic              MOSI,
    output logic              SCK_SPI,
    output logic [NUM_CS-1:0] SS,
    output logic              spi_initdone_o
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned RSP_BYTES = RSP_W / 8;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CLKS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(NCR_MAX * 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT_CLK,
        CMD_TX,
        RSP_WAIT,
        RSP_RX,
        DONE
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [CMD_W-1:0]  tx_sr;
    logic [RSP_W-2:0]  rx_sr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  rsp_last;
    logic              miso_s;
    logic              busy;
    logic              done;
    logic              timeout;

    logic              tick;
    logic [3:0]        rsp_bytes;
    logic [CNT_W-1:0]  rsp_last_d;
    logic [NUM_CS-1:0] ss_sel;
    logic [RSP_W-1:0]  rx_next;

    assign spi_flagreg_o = {timeout, done, busy};

    always_comb begin
        tick = (div_cnt == div_q);
        rx_next = {rx_sr, miso_s};

        if (spi_rsplen_i == 4'd0) begin
            rsp_bytes = 4'd1;
        end else if (spi_rsplen_i > 4'(RSP_BYTES)) begin
            rsp_bytes = 4'(RSP_BYTES);
        end else begin
            rsp_bytes = spi_rsplen_i;
        end
        rsp_last_d = CNT_W'({rsp_bytes, 3'b000}) - CNT_W'(1);

        // An index with no matching line leaves every select deasserted.
        ss_sel = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (spi_cs_sel_i == CS_W'(i)) begin
                ss_sel[i] = 1'b0;
            end
        end
    end

    // MISO is captured on the SCK rising half; all bit bookkeeping and state
    // changes happen on the falling half so SCK always ends a phase low.
    always_ff @(posedge spi_clk_i) begin
        if (spi_rst_i) begin
            state          <= IDLE;
            SCK_SPI        <= 1'b0;
            MOSI           <= 1'b1;
            SS             <= '1;
            spi_data_o     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            spi_initdone_o <= 1'b0;
            cnt            <= '0;
            div_cnt        <= '0;
            div_q          <= '0;
            tx_sr          <= '0;
            rx_sr          <= '0;
            rsp_last       <= '0;
            miso_s         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    SCK_SPI <= 1'b0;
                    MOSI    <= 1'b1;
                    div_cnt <= '0;
                    cnt     <= '0;
                    if (spi_init_i) begin
                        state <= INIT_CLK;
                        busy  <= 1'b1;
                        div_q <= spi_div_i;
                        SS    <= '1;
                    end else if (spi_start_i && spi_initdone_o) begin
                        state    <= CMD_TX;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        div_q    <= spi_div_i;
                        SS       <= ss_sel;
                        MOSI     <= spi_cmd_i[CMD_W-1];
                        tx_sr    <= spi_cmd_i << 1;
                        rx_sr    <= '0;
                        rsp_last <= rsp_last_d;
                    end
                end

                INIT_CLK, CMD_TX, RSP_WAIT, RSP_RX: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!SCK_SPI) begin
                            SCK_SPI <= 1'b1;
                            miso_s  <= MISO;
                        end else begin
                            SCK_SPI <= 1'b0;
                            case (state)
                                INIT_CLK: begin
                                    if (cnt == INIT_LAST) begin
                                        state          <= IDLE;
                                        busy           <= 1'b0;
                                        spi_initdone_o <= 1'b1;
                                        cnt            <= '0;
                                    end else begin
                                        cnt <= cnt + 1'b1;
                                    end
                                end
                                CMD_TX: begin
                                    if (cnt == CMD_LAST) begin
                                        state <= RSP_WAIT;
                                        MOSI  <= 1'b1;
                                        cnt   <= '0;
                                    end else begin
                                        MOSI  <= tx_sr[CMD_W-1];
                                        tx_sr <= tx_sr << 1;
                                        cnt   <= cnt + 1'b1;
                                    end
                                end
                                RSP_WAIT: begin
                                    if (!miso_s) begin
                                        // start bit is the response MSB
                                        state <= RSP_RX;
                                        rx_sr <= rx_next[RSP_W-2:0];
                                        cnt   <= CNT_W'(1);
                                    end else if (cnt == WAIT_LAST) begin
                                        state   <= DONE;
                                        timeout <= 1'b1;
                                        done    <= 1'b1;
                                        busy    <= 1'b0;
                                        SS      <= '1;
                                        cnt     <= '0;
                                    end else begin
                                        cnt <= cnt + 1'b1;
                                    end
                                end
                                default: begin
                                    if (cnt == rsp_last) begin
                                        state      <= DONE;
                                        spi_data_o <= rx_next;
                                        done       <= 1'b1;
                                        busy       <= 1'b0;
                                        SS         <= '1;
                                        cnt        <= '0;
                                    end else begin
                                        rx_sr <= rx_next[RSP_W-2:0];
                                        cnt   <= cnt + 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    SCK_SPI <= 1'b0;
                    MOSI    <= 1'b1;
                    SS      <= '1;
                    busy    <= 1'b0;
                    cnt     <= '0;
                    div_cnt <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sdcmd_engine.sv
`timescale 1ns/1ps
// Bench for spi_sdcmd_engine: reset/init/ignore-rule sequences, a table of
// command transactions against a behavioural card, then SCK timing and a
// mid-command reset.
module tb_spi_sdcmd_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init = 1'b0;
    logic        start = 1'b0;
    logic [0:0]  sel = '0;
    logic [47:0] cmd = '0;
    logic [3:0]  rsplen = '0;
    logic [7:0]  div = '0;
    logic        miso;
    logic [39:0] data;
    logic [2:0]  flags;
    logic        mosi;
    logic        sck;
    logic [1:0]  ss;
    logic        initdone;

    always #5 clk = ~clk;

    spi_sdcmd_engine #(
        .CMD_W    (48),
        .RSP_W    (40),
        .NUM_CS   (2),
        .DIV_W    (8),
        .INIT_CLKS(80),
        .NCR_MAX  (8)
    ) dut (
        .spi_clk_i     (clk),
        .spi_rst_i     (rst),
        .spi_init_i    (init),
        .spi_start_i   (start),
        .spi_cs_sel_i  (sel),
        .spi_cmd_i     (cmd),
        .spi_rsplen_i  (rsplen),
        .spi_div_i     (div),
        .MISO          (miso),
        .spi_data_o    (data),
        .spi_flagreg_o (flags),
        .MOSI          (mosi),
        .SCK_SPI       (sck),
        .SS            (ss),
        .spi_initdone_o(initdone)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- bus monitor and card model ----------------
    int          rise_cnt = 0;
    int          mosi_err = 0;
    int          ss_err = 0;
    logic [47:0] mosi_cap = '0;
    int          rise_base = 0;
    bit          init_mode = 1'b0;
    logic [1:0]  ss_exp = 2'b11;
    int          card_delay = 0;
    int          card_bits = 0;
    logic [63:0] card_val = '0;
    bit          card_stuck = 1'b1;
    int          k;

    always @(posedge sck) begin
        if (ss !== ss_exp) ss_err++;
        if (init_mode || (rise_cnt - rise_base) >= 48) begin
            if (mosi !== 1'b1) mosi_err++;
        end else begin
            mosi_cap = {mosi_cap[46:0], mosi};
        end
        rise_cnt++;
    end

    // Card: ones through the command and idle gap, then the response bits
    // MSB first, then ones again. Bit for rise r is presented before rise r.
    always_comb begin
        k = rise_cnt - rise_base - 48 - card_delay;
        if (card_stuck || k < 0 || k >= card_bits) miso = 1'b1;
        else miso = card_val[6'(card_bits - 1 - k)];
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_sck(input logic lvl, input string name);
        for (int c = 0; c < 200 && sck !== lvl; c++) @(negedge clk);
        if (sck !== lvl) bound_fail(name);
    endtask

    // ---------------- transaction table ----------------
    typedef struct {
        logic [47:0] cmd;
        logic [0:0]  sel;
        logic [3:0]  rsplen;
        logic [7:0]  div;
        int          delay;
        logic [63:0] rval;
        int          rbits;
        bit          stuck;
        logic [39:0] exp_data;
        logic [2:0]  exp_flags;
        logic [1:0]  exp_ss;
        int          exp_rises;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];
    vec_t v;
    int   e_mosi, e_ss, hi, lo;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{cmd:48'h40_0000_0000_95, sel:1'b0, rsplen:4'd1, div:8'd0, delay:16,
                    rval:64'h01, rbits:8, stuck:1'b0, exp_data:40'h01,
                    exp_flags:3'b010, exp_ss:2'b10, exp_rises:72};
        vecs[1] = '{cmd:48'h48_0000_01AA_87, sel:1'b0, rsplen:4'd5, div:8'd0, delay:8,
                    rval:64'h01_0000_01AA, rbits:40, stuck:1'b0, exp_data:40'h01_0000_01AA,
                    exp_flags:3'b010, exp_ss:2'b10, exp_rises:96};
        vecs[2] = '{cmd:48'h7A_0000_0000_FD, sel:1'b1, rsplen:4'd5, div:8'd0, delay:0,
                    rval:64'h0, rbits:0, stuck:1'b1, exp_data:40'h01_0000_01AA,
                    exp_flags:3'b110, exp_ss:2'b01, exp_rises:112};
        vecs[3] = '{cmd:48'h77_0000_0000_65, sel:1'b1, rsplen:4'd0, div:8'd0, delay:0,
                    rval:64'h05FF, rbits:16, stuck:1'b0, exp_data:40'h05,
                    exp_flags:3'b010, exp_ss:2'b01, exp_rises:56};
        vecs[4] = '{cmd:48'h4D_0000_0000_0D, sel:1'b0, rsplen:4'd9, div:8'd1, delay:3,
                    rval:64'h3F12_3456_789A, rbits:48, stuck:1'b0, exp_data:40'h3F_1234_5678,
                    exp_flags:3'b010, exp_ss:2'b10, exp_rises:91};
        vecs[5] = '{cmd:48'h69_4000_0000_77, sel:1'b1, rsplen:4'd2, div:8'd2, delay:5,
                    rval:64'h7E55, rbits:16, stuck:1'b0, exp_data:40'h7E55,
                    exp_flags:3'b010, exp_ss:2'b01, exp_rises:69};

        // ---- reset state ----
        repeat (10) @(negedge clk);
        check("rst_sck", 64'(sck), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd1);
        check("rst_ss", 64'(ss), 64'h3);
        check("rst_data", 64'(data), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_initdone", 64'(initdone), 64'd0);
        rst = 1'b0;

        // ---- start before init is ignored ----
        cmd = 48'h40_0000_0000_95;
        rise_base = rise_cnt;
        pulse_start();
        repeat (10) @(negedge clk);
        check("preinit_flags", 64'(flags), 64'd0);
        check("preinit_ss", 64'(ss), 64'h3);
        check("preinit_rises", 64'(rise_cnt - rise_base), 64'd0);

        // ---- init clock train ----
        ss_exp = 2'b11; init_mode = 1'b1; div = 8'd0;
        rise_base = rise_cnt; e_mosi = mosi_err; e_ss = ss_err;
        @(negedge clk); init = 1'b1;
        @(negedge clk); init = 1'b0;
        check("init_busy", 64'(flags), 64'd1);
        for (int c = 0; c < 1000 && initdone !== 1'b1; c++) @(negedge clk);
        if (initdone !== 1'b1) bound_fail("init_done_wait");
        check("init_pulses", 64'(rise_cnt - rise_base), 64'd80);
        check("init_mosi_high", 64'(mosi_err - e_mosi), 64'd0);
        check("init_ss_high", 64'(ss_err - e_ss), 64'd0);
        check("init_flags", 64'(flags), 64'd0);
        check("init_sck_low", 64'(sck), 64'd0);
        init_mode = 1'b0;

        // ---- command table ----
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            cmd = v.cmd; sel = v.sel; rsplen = v.rsplen; div = v.div;
            card_delay = v.delay; card_val = v.rval; card_bits = v.rbits;
            card_stuck = v.stuck; ss_exp = v.exp_ss;
            rise_base = rise_cnt; e_mosi = mosi_err; e_ss = ss_err;
            pulse_start();
            check($sformatf("v%0d_busy", i), 64'(flags), 64'd1);
            // inputs after acceptance must not disturb the transfer
            cmd = ~v.cmd; sel = ~v.sel; rsplen = 4'd3; div = v.div + 8'd2;
            repeat (3) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
            check($sformatf("v%0d_busy_restart", i), 64'(flags), 64'd1);
            for (int c = 0; c < 5000 && flags[1] !== 1'b1; c++) @(negedge clk);
            if (flags[1] !== 1'b1) bound_fail($sformatf("v%0d_done_wait", i));
            check($sformatf("v%0d_data", i), 64'(data), 64'(v.exp_data));
            check($sformatf("v%0d_flags", i), 64'(flags), 64'(v.exp_flags));
            check($sformatf("v%0d_done_ss", i), 64'(ss), 64'h3);
            check($sformatf("v%0d_done_sck", i), 64'(sck), 64'd0);
            check($sformatf("v%0d_done_mosi", i), 64'(mosi), 64'd1);
            check($sformatf("v%0d_rises", i), 64'(rise_cnt - rise_base), 64'(v.exp_rises));
            check($sformatf("v%0d_frame", i), 64'(mosi_cap), 64'(v.cmd));
            check($sformatf("v%0d_idle_mosi", i), 64'(mosi_err - e_mosi), 64'd0);
            check($sformatf("v%0d_ss_sel", i), 64'(ss_err - e_ss), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_sticky_flags", i), 64'(flags), 64'(v.exp_flags));
        end

        // ---- SCK timing with divider 3, then reset mid-command ----
        cmd = 48'h51_0000_0000_55; sel = 1'b0; rsplen = 4'd1; div = 8'd3;
        card_stuck = 1'b1; ss_exp = 2'b10; rise_base = rise_cnt;
        pulse_start();
        div = 8'd0;
        wait_sck(1'b1, "div3_rise1");
        wait_sck(1'b0, "div3_fall1");
        wait_sck(1'b1, "div3_rise2");
        hi = 0;
        for (int c = 0; c < 100 && sck === 1'b1; c++) begin hi++; @(negedge clk); end
        lo = 0;
        for (int c = 0; c < 100 && sck === 1'b0; c++) begin lo++; @(negedge clk); end
        check("div3_sck_high", 64'(hi), 64'd4);
        check("div3_sck_low", 64'(lo), 64'd4);

        for (int c = 0; c < 2000 && (rise_cnt - rise_base) < 21; c++) @(negedge clk);
        if ((rise_cnt - rise_base) < 21) bound_fail("bit20_wait");
        check("pre_abort_busy", 64'(flags), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ss", 64'(ss), 64'h3);
        check("abort_mosi", 64'(mosi), 64'd1);
        check("abort_sck", 64'(sck), 64'd0);
        check("abort_flags", 64'(flags), 64'd0);
        check("abort_initdone", 64'(initdone), 64'd0);
        check("abort_data", 64'(data), 64'd0);
        @(negedge clk); rst = 1'b0;
        rise_base = rise_cnt;
        pulse_start();
        repeat (20) @(negedge clk);
        check("post_abort_flags", 64'(flags), 64'd0);
        check("post_abort_rises", 64'(rise_cnt - rise_base), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
